// File: rtl/frame_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_buf_pkg
//  Description : Shared definitions for the frame-buffer scan-out block:
//                scan FSM state encoding, raster-derived constant helpers,
//                the sync-polarity helper and the timing of the default
//                640x480 raster.
//  Contents    : scan_state_e      - IDLE / RUN state encoding
//                calc_total()      - sum of active + porches + sync
//                calc_lat()        - counter-to-output latency
//                cnt_width()       - counter width for a given modulus
//                sync_level()      - maps "sync active" to the pin level
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_buf_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } scan_state_e;

  function automatic int unsigned calc_total(
    input int unsigned active,
    input int unsigned fp,
    input int unsigned sync,
    input int unsigned bp
  );
    return active + fp + sync + bp;
  endfunction

  // One cycle to register the read enable, RD_LATENCY for the buffer,
  // one more to register the returned word.
  function automatic int unsigned calc_lat(input int unsigned rd_latency);
    return rd_latency + 2;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

  // Timing of the default 640x480 raster.
  localparam int unsigned c_DEF_H_TOTAL = calc_total(640, 16, 96, 48);
  localparam int unsigned c_DEF_V_TOTAL = calc_total(480, 10, 2, 33);
  localparam int unsigned c_DEF_LAT     = calc_lat(1);

endpackage
`default_nettype wire

// File: rtl/scan_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : scan_delay_line
//  Description : WIDTH x DEPTH shift register with asynchronous active-low
//                clear. Carries the raster flags (and the capture strobe)
//                so they line up with the returned pixel data.
//  Ports       : clk    in  1      clock, rising edge
//                rst_n  in  1      asynchronous clear, active-low
//                i_d    in  WIDTH  stage-0 input
//                o_q    out WIDTH  output after DEPTH cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_delay_line
  import frame_buf_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/frame_buf_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : frame_buf_scanout
//  Description : Read-side consumer of a double-buffered frame buffer.
//                Generates raster timing, issues one active-low read per
//                active pixel, aligns the returned words with de/hsync/vsync
//                and pulses buf_swap once per frame.
//  Ports       : rd_clk     in  1       clock, rising edge
//                reset      in  1       asynchronous reset, active-low
//                en         in  1       run request, honoured at frame edges
//                data_in    in  DATA_W  word from the buffer read port
//                rd_en_out  out 1       read enable to the buffer, active-low
//                buf_swap   out 1       one-cycle pulse after last active line
//                                       has been requested
//                de         out 1       data enable, aligned with pixel_out
//                hsync      out 1       horizontal sync, level per SYNC_POL
//                vsync      out 1       vertical sync, level per SYNC_POL
//                pixel_out  out PIX_W   pixel, zero when de=0
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_buf_scanout
  import frame_buf_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PIX_W      = 24,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned RD_LATENCY = 1,
  parameter bit          SYNC_POL   = 1'b0
) (
  input  logic              rd_clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  output logic              rd_en_out,
  output logic              buf_swap,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic [PIX_W-1:0]  pixel_out
);

  localparam int unsigned c_H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned c_V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned c_LAT     = calc_lat(RD_LATENCY);
  localparam int unsigned c_H_W     = cnt_width(c_H_TOTAL);
  localparam int unsigned c_V_W     = cnt_width(c_V_TOTAL);

  localparam logic [c_H_W-1:0] c_H_LAST = c_H_W'(c_H_TOTAL - 1);
  localparam logic [c_V_W-1:0] c_V_LAST = c_V_W'(c_V_TOTAL - 1);

  // Sync windows as [begin, end) bounds in 32-bit space so an end equal to
  // the total never aliases back onto a narrow counter.
  localparam int unsigned c_HS_BEG = H_ACTIVE + H_FP;
  localparam int unsigned c_HS_END = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned c_VS_BEG = V_ACTIVE + V_FP;
  localparam int unsigned c_VS_END = V_ACTIVE + V_FP + V_SYNC;

  // --------------------------------------------------------------------------
  // Scan state machine
  // --------------------------------------------------------------------------
  scan_state_e r_state;
  scan_state_e w_state_nxt;

  logic [c_H_W-1:0] r_h_cnt;
  logic [c_V_W-1:0] r_v_cnt;

  logic w_run;
  logic w_h_last;
  logic w_v_last;
  logic w_frame_end;

  assign w_run       = (r_state == ST_RUN);
  assign w_h_last    = (r_h_cnt == c_H_LAST);
  assign w_v_last    = (r_v_cnt == c_V_LAST);
  assign w_frame_end = w_h_last && w_v_last;

  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // en only matters in IDLE or on the last cycle of a frame, so dropping it
  // mid-frame lets the current frame complete.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_frame_end && !en) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Raster counters: advance only in RUN, parked at 0 otherwise so the first
  // RUN cycle always sits at h=0, v=0.
  // --------------------------------------------------------------------------
  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_run) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end else begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Raster decode at the counter position
  // --------------------------------------------------------------------------
  logic w_pix_act;
  logic w_hs_act;
  logic w_vs_act;
  logic w_swap;

  assign w_pix_act = w_run && (32'(r_h_cnt) < H_ACTIVE) && (32'(r_v_cnt) < V_ACTIVE);
  assign w_hs_act  = w_run && (32'(r_h_cnt) >= c_HS_BEG) && (32'(r_h_cnt) < c_HS_END);
  assign w_vs_act  = w_run && (32'(r_v_cnt) >= c_VS_BEG) && (32'(r_v_cnt) < c_VS_END);
  // h=0 of the first blanking line: every active read has been issued.
  assign w_swap    = w_run && (r_h_cnt == '0) && (32'(r_v_cnt) == V_ACTIVE);

  // --------------------------------------------------------------------------
  // Read request and buffer-swap pulse
  // --------------------------------------------------------------------------
  logic r_rd_en_n;
  logic r_buf_swap;

  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      r_rd_en_n  <= 1'b1;
      r_buf_swap <= 1'b0;
    end else begin
      r_rd_en_n  <= ~w_pix_act;
      r_buf_swap <= w_swap;
    end
  end

  // --------------------------------------------------------------------------
  // Capture strobe: the read enable delayed by the buffer latency marks the
  // cycle in which data_in carries a requested word.
  // --------------------------------------------------------------------------
  logic w_cap_vld;

  generate
    if (RD_LATENCY == 0) begin : g_cap_direct
      assign w_cap_vld = ~r_rd_en_n;
    end else begin : g_cap_pipe
      scan_delay_line #(
        .WIDTH (1),
        .DEPTH (RD_LATENCY)
      ) u_cap_vld (
        .clk   (rd_clk),
        .rst_n (reset),
        .i_d   (~r_rd_en_n),
        .o_q   (w_cap_vld)
      );
    end
  endgenerate

  logic [PIX_W-1:0] r_pixel;

  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      r_pixel <= '0;
    end else begin
      r_pixel <= w_cap_vld ? data_in[PIX_W-1:0] : '0;
    end
  end

  // Bits above PIX_W are not displayed.
  logic w_unused_data;
  assign w_unused_data = ^data_in;

  // --------------------------------------------------------------------------
  // Flag alignment: {de, hsync, vsync} travel c_LAT stages so they reach the
  // pins in the same cycle as the pixel captured for that position.
  // Flags are carried as "active" so a cleared line reads as inactive sync.
  // --------------------------------------------------------------------------
  logic [2:0] w_flags_dly;

  scan_delay_line #(
    .WIDTH (3),
    .DEPTH (c_LAT)
  ) u_flag_dly (
    .clk   (rd_clk),
    .rst_n (reset),
    .i_d   ({w_pix_act, w_hs_act, w_vs_act}),
    .o_q   (w_flags_dly)
  );

  assign rd_en_out = r_rd_en_n;
  assign buf_swap  = r_buf_swap;
  assign de        = w_flags_dly[2];
  assign hsync     = sync_level(w_flags_dly[1], SYNC_POL);
  assign vsync     = sync_level(w_flags_dly[0], SYNC_POL);
  assign pixel_out = r_pixel;

endmodule
`default_nettype wire

// File: tb/tb_frame_buf_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_buf_scanout
//  Description : Self-checking bench for frame_buf_scanout on a small 8x6
//                raster. A behavioural buffer returns sequence-numbered words
//                with random upper bits; a frame-position model predicts
//                every output on every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_buf_scanout;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int RDL   = 1;
  localparam int LAT   = RDL + 2;
  localparam int HT    = HA + HF + HS + HB;
  localparam int VT    = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } rec_t;

  logic        rd_clk  = 1'b0;
  logic        reset   = 1'b1;
  logic        en      = 1'b0;
  logic [31:0] data_in = 32'hFFFFFFFF;
  logic        rd_en_out, buf_swap, de, hsync, vsync;
  logic [23:0] pixel_out;

  always #5 rd_clk = ~rd_clk;

  frame_buf_scanout #(
    .DATA_W(32), .PIX_W(24),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .RD_LATENCY(RDL), .SYNC_POL(1'b0)
  ) dut (
    .rd_clk(rd_clk), .reset(reset), .en(en), .data_in(data_in),
    .rd_en_out(rd_en_out), .buf_swap(buf_swap), .de(de),
    .hsync(hsync), .vsync(vsync), .pixel_out(pixel_out)
  );

  // Buffer model: a word requested in one cycle appears on data_in in the next.
  logic [23:0] exp_q[$];
  int unsigned next_seq = 1;

  always @(posedge rd_clk) begin
    if (reset && !rd_en_out) begin
      data_in <= {8'($urandom), 24'(next_seq)};
      exp_q.push_back(24'(next_seq));
      next_seq = next_seq + 1;
    end else if (reset) begin
      data_in <= $urandom;
    end else begin
      data_in <= 32'hFFFFFFFF;
    end
  end

  // Frame-position model: m_k is the linear position v*HT+h of the current cycle.
  bit   m_run;
  int   m_k;
  rec_t hist[$];
  logic exp_rd_n, exp_swap;

  int n_checks = 0;
  int n_fail   = 0;

  int   w_cyc, win_reads, win_vs_low, first_de, first_hs, span_reads, span_de;
  logic prev_de, prev_hs;
  int   swap_cyc[$];
  int   swap_reads[$];

  function automatic rec_t pos_rec(bit run, int k);
    int   h;
    int   v;
    rec_t r;
    h = k % HT;
    v = k / HT;
    r.act = run && (h < HA) && (v < VA);
    r.hs  = run && (h >= HA + HF) && (h < HA + HF + HS);
    r.vs  = run && (v >= VA + VF) && (v < VA + VF + VS);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_k   = 0;
    hist.delete();
    for (int i = 0; i < LAT; i++) hist.push_back('0);
    exp_rd_n = 1'b1;
    exp_swap = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    rec_t        d;
    logic [23:0] ep;
    d  = hist[LAT-1];
    ep = 24'h0;
    if (d.act) begin
      if (exp_q.size() > 0) ep = exp_q.pop_front();
      else                  ep = 24'hBADBAD;
    end
    chk("rd_en_out", 32'(rd_en_out), 32'(exp_rd_n));
    chk("buf_swap",  32'(buf_swap),  32'(exp_swap));
    chk("de",        32'(de),        32'(d.act));
    chk("hsync",     32'(hsync),     32'(!d.hs));
    chk("vsync",     32'(vsync),     32'(!d.vs));
    chk("pixel_out", 32'(pixel_out), 32'(ep));
  endtask

  task automatic tick();
    rec_t r;
    @(posedge rd_clk);
    if (!reset) begin
      model_reset();
    end else begin
      r        = pos_rec(m_run, m_k);
      exp_rd_n = !r.act;
      exp_swap = m_run && (m_k == VA * HT);
      hist.push_front(r);
      void'(hist.pop_back());
      if (!m_run) begin
        if (en) begin
          m_run = 1'b1;
          m_k   = 0;
        end
      end else if (m_k == FRAME - 1) begin
        m_k   = 0;
        m_run = en;
      end else begin
        m_k++;
      end
    end
    @(negedge rd_clk);
    check_outputs();
    if (!rd_en_out) begin
      win_reads++;
      span_reads++;
    end
    if (de) span_de++;
    if (!vsync) win_vs_low++;
    if (de && !prev_de && first_de < 0) first_de = w_cyc;
    if (!hsync && prev_hs && first_hs < 0) first_hs = w_cyc;
    if (buf_swap) begin
      swap_cyc.push_back(w_cyc);
      swap_reads.push_back(win_reads);
    end
    prev_de = de;
    prev_hs = hsync;
    w_cyc++;
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_rd_en_out"}, 32'(rd_en_out), 32'd1);
    chk({pfx, "_buf_swap"},  32'(buf_swap),  32'd0);
    chk({pfx, "_de"},        32'(de),        32'd0);
    chk({pfx, "_hsync"},     32'(hsync),     32'd1);
    chk({pfx, "_vsync"},     32'(vsync),     32'd1);
    chk({pfx, "_pixel_out"}, 32'(pixel_out), 32'd0);
  endtask

  initial begin
    int n;
    int n_rd;
    int n_de;
    model_reset();
    w_cyc = 0; win_reads = 0; win_vs_low = 0; span_reads = 0; span_de = 0;
    first_de = -1; first_hs = -1; prev_de = 1'b0; prev_hs = 1'b1;

    // Reset with en already high and an all-ones bus.
    #2 reset = 1'b0;
    en = 1'b1;
    #1 check_reset_values("reset");
    repeat (3) tick();

    // Free run three frames; window index 0 is the first RUN cycle (k=0).
    reset = 1'b1;
    w_cyc = 0; win_reads = 0; win_vs_low = 0;
    first_de = -1; first_hs = -1; prev_de = 1'b0; prev_hs = 1'b1;
    swap_cyc.delete();
    swap_reads.delete();
    repeat (3 * FRAME + 1) tick();

    chk("reads_3_frames",    32'(win_reads),  32'(3 * HA * VA));
    chk("first_de_cycle",    32'(first_de),   32'(LAT));
    chk("first_hsync_cycle", 32'(first_hs),   32'(HA + HF + LAT));
    chk("vsync_low_cycles",  32'(win_vs_low), 32'(3 * HT));
    chk("swap_count",        32'(swap_cyc.size()), 32'd3);
    for (int i = 0; i < swap_cyc.size(); i++) begin
      chk("swap_after_reads", 32'(swap_reads[i]), 32'(HA * VA * (i + 1)));
      if (i > 0) chk("swap_spacing", 32'(swap_cyc[i] - swap_cyc[i-1]), 32'(FRAME));
    end

    // Stop: a short en glitch inside line 0 is ignored, then en drops at v=1.
    span_reads = 0;
    span_de    = 0;
    en = 1'b0;
    repeat ($urandom_range(1, 3)) tick();
    en = 1'b1;
    n = 0;
    while (!(m_run && m_k == HT) && n < FRAME) begin
      tick();
      n++;
    end
    chk("wait_v1_timeout", 32'(n < FRAME), 32'd1);
    en = 1'b0;
    n = 0;
    while (m_run && n < 2 * FRAME) begin
      tick();
      n++;
    end
    chk("stop_timeout", 32'(n < 2 * FRAME), 32'd1);
    repeat (LAT + $urandom_range(4, 10)) tick();
    chk("stop_frame_reads", 32'(span_reads), 32'(HA * VA));
    chk("stop_frame_de",    32'(span_de),    32'(HA * VA));

    // Restart: edge enters RUN at h=0, the first read follows one cycle later.
    en = 1'b1;
    n  = 0;
    do begin
      tick();
      n++;
    end while (rd_en_out && n < 20);
    chk("restart_first_read", 32'(n), 32'd2);

    // Mid-line reset at h=2, v=1 with reads and pixels in flight.
    n = 0;
    while (!(m_run && m_k == HT + 2) && n < 2 * FRAME) begin
      tick();
      n++;
    end
    chk("wait_h2v1_timeout", 32'(n < 2 * FRAME), 32'd1);
    reset = 1'b0;
    #1 check_reset_values("midreset");
    model_reset();
    repeat (3) tick();
    reset = 1'b1;
    n_rd = -1;
    n_de = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (n_rd < 0 && !rd_en_out) n_rd = i;
      if (n_de < 0 && de) n_de = i;
    end
    chk("post_reset_first_read", 32'(n_rd), 32'd2);
    // Read is issued one cycle after its position; de appears LAT after it.
    chk("post_reset_de_gap", 32'(n_de - n_rd), 32'(LAT - 1));
    repeat (FRAME + 8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
